controlador_rolagem: RTL

Scroll controller for the electronic panel's 16-bit line registers. It turns three front-panel push-buttons into the 2-bit mode code `{ch1,ch0}` that every line register shares on the same `CLK`. It issues a one-cycle load after reset or on request, and one-cycle shift pulses at a programmable rate while scrolling, so the visible 7-column window rolls at human speed. It sits directly upstream of all line registers and drives their `ch0`/`ch1` in parallel.

---
 rtl/controlador_rolagem.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/controlador_rolagem.sv
// controlador_rolagem: turns the start/direction/reload buttons into the {ch1,ch0} mode code
// shared by the panel line registers. Optional button filter: CONTROLADOR_ROLAGEM_DEBOUNCE_EN.
module controlador_rolagem #(
  parameter int unsigned DIV        = 12_500_000,
  parameter int unsigned DEB_CYCLES = 250_000
) (
  input  logic CLK,
  input  logic reset,
  input  logic botao_inicio_n,
  input  logic botao_direcao_n,
  input  logic botao_carga_n,
  output logic ch0,
  output logic ch1,
  output logic rodando,
  output logic direcao
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  if (DIV < 2 || DEB_CYCLES < 1) begin : g_param_invalido
    $error("controlador_rolagem: DIV must be >= 2 and DEB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    CARGA   = 2'b00,
    PARADO  = 2'b01,
    ROLANDO = 2'b10
  } estado_t;

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_DIR  = 2'b01,
    M_ESQ  = 2'b10,
    M_LOAD = 2'b11
  } modo_t;

  // Button lanes: [0] start/pause, [1] direction, [2] reload.
  logic [2:0] botao_n;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] nivel_q;
  logic [2:0] nivel_d;
  logic [2:0] anterior_q;
  logic [2:0] ev_q;
  logic       ev_inicio;
  logic       ev_dir;
  logic       ev_carga;

  estado_t       estado_q;
  estado_t       estado_d;
  modo_t         modo_q;
  modo_t         modo_d;
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          direcao_q;
  logic          direcao_d;
  logic          wrap;

  assign botao_n = {botao_carga_n, botao_direcao_n, botao_inicio_n};

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~botao_n;
      sync2_q <= sync1_q;
    end
  end

`ifdef CONTROLADOR_ROLAGEM_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES);

  logic [DW-1:0] deb_q [3];
  logic [DW-1:0] deb_d [3];

  // The level flips on the sample after DEB_CYCLES differing samples have been counted.
  always_comb begin
    nivel_d = nivel_q;
    for (int unsigned b = 0; b < 3; b++) begin
      deb_d[b] = '0;
      if (sync2_q[b] != nivel_q[b]) begin
        if (deb_q[b] == D_LAST) begin
          nivel_d[b] = sync2_q[b];
        end else begin
          deb_d[b] = deb_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned b = 0; b < 3; b++) begin
      if (reset) begin
        deb_q[b] <= '0;
      end else begin
        deb_q[b] <= deb_d[b];
      end
    end
  end
`else
  always_comb begin
    nivel_d = sync2_q;
  end
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      nivel_q    <= '0;
      anterior_q <= '0;
      ev_q       <= '0;
    end else begin
      nivel_q    <= nivel_d;
      anterior_q <= nivel_q;
      ev_q       <= nivel_q & ~anterior_q;
    end
  end

  assign ev_inicio = ev_q[0];
  assign ev_dir    = ev_q[1];
  assign ev_carga  = ev_q[2];

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = '0;
    modo_d    = M_HOLD;
    direcao_d = direcao_q ^ ev_dir;
    wrap      = (estado_q == ROLANDO) && (cnt_q == P_LAST);

    case (estado_q)
      CARGA:   estado_d = PARADO;
      PARADO:  if (ev_inicio) estado_d = ROLANDO;
      ROLANDO: if (ev_inicio) estado_d = PARADO;
      default: estado_d = CARGA;
    endcase

    if (ev_carga) begin
      estado_d = CARGA;
    end

    if (estado_q == ROLANDO && estado_d == ROLANDO) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    // The load code is the registered image of the CARGA cycle; a wrap only fires if scrolling continues.
    if (estado_q == CARGA) begin
      modo_d = M_LOAD;
    end else if (wrap && estado_d == ROLANDO) begin
      modo_d = direcao_q ? M_DIR : M_ESQ;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      estado_q  <= CARGA;
      modo_q    <= M_HOLD;
      cnt_q     <= '0;
      direcao_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      modo_q    <= modo_d;
      cnt_q     <= cnt_d;
      direcao_q <= direcao_d;
    end
  end

  assign {ch1, ch0} = modo_q;
  assign rodando    = (estado_q == ROLANDO);
  assign direcao    = direcao_q;

endmodule
